image_pipe_frame_src: RTL and testbench

//  Frame-level stream transmitter for the image_pipe valid/end/busy protocol.
//  On a start command it emits one frame of W*H pixel words on the im_* master port,

---
 rtl/image_pipe_pkg.sv | 29 ++
 rtl/image_pipe_lfsr32.sv | 28 ++
 rtl/image_pipe_frame_src.sv | 175 +++++++++++++++++
 tb/tb_image_pipe_frame_src.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_pipe_pkg.sv
// Shared types and constants for the image_pipe frame source.
// Holds pattern/state encodings and the 32-bit Galois LFSR helpers.
package image_pipe_pkg;

    typedef enum logic [1:0] {
        PAT_CNT,
        PAT_XY,
        PAT_LFSR,
        PAT_CONST
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } src_state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // An all-zero state would lock the LFSR, so seed 0 is promoted to 1.
    function automatic logic [31:0] lfsr_init(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/image_pipe_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and single-step advance.
// Load has priority over step.
module image_pipe_lfsr32
    import image_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_step,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= lfsr_init(i_seed);
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/image_pipe_frame_src.sv
// Frame transmitter: emits W*H pattern words on the im_* port with
// end-of-frame marking, busy back-pressure and abort.
module image_pipe_frame_src
    import image_pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int XW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] frame_w,
    input  logic [XW-1:0] frame_h,
    input  logic [1:0]    pattern_sel,
    input  logic [31:0]   seed,
    input  logic          abort,
    output logic [DW-1:0] im_data_out,
    output logic          im_valid_out,
    output logic          im_end_out,
    input  logic          im_busy_in,
    output logic          active,
    output logic          done
);

    src_state_e    r_state;
    pattern_e      r_sel;
    logic [XW-1:0] r_w;
    logic [XW-1:0] r_h;
    logic [XW-1:0] r_x;
    logic [XW-1:0] r_y;
    logic [31:0]   r_seed;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_end;
    logic          r_active;
    logic          r_done;

    logic          w_start;
    logic          w_xfer;
    logic          w_zero;
    pattern_e      w_sel_in;
    logic [XW-1:0] w_nx;
    logic [XW-1:0] w_ny;
    logic [DW-1:0] w_cnt_next;
    logic          w_end_next;
    logic          w_end_first;
    logic [DW-1:0] w_data_next;
    logic [DW-1:0] w_data_first;
    logic [31:0]   w_lfsr_state;

    assign w_start  = (r_state == IDLE) && start && !abort;
    assign w_xfer   = (r_state == RUN) && r_valid && !im_busy_in;
    assign w_zero   = (frame_w == '0) || (frame_h == '0);
    assign w_sel_in = pattern_e'(pattern_sel);
    assign w_end_first = (frame_w == XW'(1)) && (frame_h == XW'(1));

    image_pipe_lfsr32 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_start),
        .i_seed  (seed),
        .i_step  (w_xfer && !abort),
        .o_state (w_lfsr_state)
    );

    always_comb begin
        w_data_first = '0;
        unique case (w_sel_in)
            PAT_CNT:   w_data_first = DW'(seed);
            PAT_XY:    w_data_first = '0;
            PAT_LFSR:  w_data_first = DW'(lfsr_init(seed));
            PAT_CONST: w_data_first = DW'(seed);
            default:   w_data_first = '0;
        endcase
    end

    // Coordinates and pattern of the word following the one on the port.
    always_comb begin
        w_nx = r_x + XW'(1);
        w_ny = r_y;
        if (r_x == r_w - XW'(1)) begin
            w_nx = '0;
            w_ny = r_y + XW'(1);
        end
        w_cnt_next  = r_cnt + DW'(1);
        w_end_next  = (w_nx == r_w - XW'(1)) && (w_ny == r_h - XW'(1));
        w_data_next = '0;
        unique case (r_sel)
            PAT_CNT:   w_data_next = w_cnt_next;
            PAT_XY:    w_data_next = DW'({16'(w_ny), 16'(w_nx)});
            PAT_LFSR:  w_data_next = DW'(lfsr_next(w_lfsr_state));
            PAT_CONST: w_data_next = DW'(r_seed);
            default:   w_data_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sel    <= PAT_CNT;
            r_w      <= '0;
            r_h      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_seed   <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_end    <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (abort) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_end    <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_w    <= frame_w;
                        r_h    <= frame_h;
                        r_sel  <= w_sel_in;
                        r_seed <= seed;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_cnt  <= DW'(seed);
                        if (w_zero) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= RUN;
                            r_active <= 1'b1;
                            r_valid  <= 1'b1;
                            r_data   <= w_data_first;
                            r_end    <= w_end_first;
                        end
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        if (r_end) begin
                            r_state  <= DONE;
                            r_valid  <= 1'b0;
                            r_end    <= 1'b0;
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_x    <= w_nx;
                            r_y    <= w_ny;
                            r_cnt  <= w_cnt_next;
                            r_data <= w_data_next;
                            r_end  <= w_end_next;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign im_data_out  = r_data;
    assign im_valid_out = r_valid;
    assign im_end_out   = r_end;
    assign active       = r_active;
    assign done         = r_done;

endmodule

// File: tb/tb_image_pipe_frame_src.sv
// Bench for image_pipe_frame_src: directed and random frames
// compared word by word against a queue-based frame model.
module tb_image_pipe_frame_src;

    localparam int DW = 32;
    localparam int XW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [XW-1:0] fw = '0;
    logic [XW-1:0] fh = '0;
    logic [1:0]    psel = '0;
    logic [31:0]   seed = '0;
    logic          abort = 1'b0;
    logic          busy = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
    logic          eof;
    logic          active;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    logic [31:0] g_first[2];

    image_pipe_frame_src #(.DW(DW), .XW(XW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .frame_w      (fw),
        .frame_h      (fh),
        .pattern_sel  (psel),
        .seed         (seed),
        .abort        (abort),
        .im_data_out  (data),
        .im_valid_out (valid),
        .im_end_out   (eof),
        .im_busy_in   (busy),
        .active       (active),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame model: pixel n sits at (n % w, n / w).
    task automatic build(input int w, input int h, input int ps,
                         input logic [31:0] sd);
        logic [31:0] l;
        logic [15:0] x16;
        logic [15:0] y16;
        exp_q.delete();
        l = (sd == 32'h0) ? 32'h1 : sd;
        for (int n = 0; n < w * h; n++) begin
            x16 = 16'(n % w);
            y16 = 16'(n / w);
            case (ps)
                0: exp_q.push_back(sd + 32'(n));
                1: exp_q.push_back({y16, x16});
                2: begin
                    exp_q.push_back(l);
                    if (l[0]) l = (l >> 1) ^ 32'h8020_0003;
                    else      l = l >> 1;
                end
                default: exp_q.push_back(sd);
            endcase
        end
    endtask

    task automatic run_frame(input int w, input int h, input int ps,
                             input logic [31:0] sd, input int bmode,
                             input bit poke);
        int total;
        int k;
        int i;
        int budget;
        bit seen;
        bit hold;
        logic [DW-1:0] hold_d;
        logic hold_e;
        build(w, h, ps, sd);
        total = exp_q.size();
        k = 0;
        i = 0;
        seen = 0;
        hold = 0;
        hold_d = '0;
        hold_e = 0;
        budget = total * 4 + 20;
        @(negedge clk);
        fw = XW'(w);
        fh = XW'(h);
        psel = 2'(ps);
        seed = sd;
        start = 1'b1;
        while (!seen && i < budget) begin
            @(negedge clk);
            i++;
            start = 1'b0;
            if (poke && i == 2 && total >= 4) begin
                start = 1'b1;
                fw = 12'd1;
                fh = 12'd1;
                seed = ~sd;
            end
            case (bmode)
                1: busy = ($urandom_range(0, 99) < 30);
                2: busy = (i >= 2 && i <= 4);
                default: busy = 1'b0;
            endcase
            #1;
            if (i == 1 && total > 0) check("latency", valid, 1);
            if (total == 0) check("zero_active", active, 0);
            if (done) begin
                seen = 1;
                check("done_words", k, total);
                check("done_active", active, 0);
                check("done_valid", valid, 0);
            end else if (valid) begin
                check("active_valid", active, 1);
                if (hold) begin
                    check("hold_data", data, hold_d);
                    check("hold_end", eof, hold_e);
                end
                if (k >= total) begin
                    check("extra_word", valid, 0);
                end else if (!busy) begin
                    check("data", data, DW'(exp_q[k]));
                    check("end", eof, (k == total - 1));
                    if (k < 2) g_first[k] = data;
                    k++;
                end
                hold = busy;
                hold_d = data;
                hold_e = eof;
            end else begin
                if (hold) check("hold_valid", valid, 1);
                hold = 0;
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        busy = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("done_pulse_end", done, 0);
        check("idle_valid", valid, 0);
    endtask

    task automatic abort_test();
        int i;
        @(negedge clk);
        fw = 12'd5;
        fh = 12'd3;
        psel = 2'd0;
        seed = 32'd7;
        start = 1'b1;
        for (i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            busy = (i >= 3);
            abort = (i == 4);
        end
        @(negedge clk);
        abort = 1'b0;
        busy = 1'b0;
        #1;
        check("abort_valid", valid, 0);
        check("abort_active", active, 0);
        check("abort_end", eof, 0);
        check("abort_done", done, 0);
        for (i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post_abort_done", done, 0);
            check("post_abort_valid", valid, 0);
        end
        // start together with abort in IDLE must be ignored
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("abort_start_valid", valid, 0);
        check("abort_start_active", active, 0);
        check("abort_start_done", done, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_end", eof, 0);
        check("rst_active", active, 0);
        check("rst_done", done, 0);
        check("rst_data", data, 0);
        rst_n = 1'b1;

        run_frame(4, 2, 0, 32'd100, 0, 0);
        run_frame(3, 2, 1, 32'd0, 2, 0);
        run_frame(4, 2, 2, 32'd0, 0, 0);
        check("lfsr0_w0", g_first[0], 32'h1);
        check("lfsr0_w1", g_first[1], 32'h8020_0003);
        run_frame(4, 2, 2, 32'd1, 1, 0);
        check("lfsr1_w1", g_first[1], 32'h8020_0003);
        run_frame(0, 3, 0, 32'd5, 0, 0);
        run_frame(3, 0, 1, 32'd5, 0, 0);
        abort_test();
        run_frame(5, 2, 0, 32'hFFFF_FFFE, 0, 1);
        run_frame(1, 3, 3, 32'hA5, 0, 0);
        run_frame(6, 1, 0, 32'd9, 1, 0);

        for (int r = 0; r < 25; r++) begin
            run_frame($urandom_range(0, 6), $urandom_range(0, 5),
                      $urandom_range(0, 3), $urandom, 1,
                      1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
